// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite master: each command becomes one NONSEQ word
// transfer followed by IDLE bus cycles; the result returns on a valid/ready channel.
module ahb_lite_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0]  wait_cnt_d;
    logic              timeout_hit;
    logic [31:0]       haddr_q;
    logic              hwrite_q;
    logic [31:0]       hwdata_q;
    logic [1:0]        htrans_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    // Byte lanes below word granularity are never driven onto the bus.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^cmd_addr[1:0];

    assign wait_cnt_d  = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_LIMIT);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            haddr_q       <= '0;
            hwrite_q      <= 1'b0;
            hwdata_q      <= '0;
            htrans_q      <= TRANS_IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        haddr_q     <= {cmd_addr[31:2], 2'b00};
                        hwrite_q    <= cmd_write;
                        hwdata_q    <= cmd_wdata;
                        wait_cnt_q  <= '0;
                        htrans_q    <= TRANS_NONSEQ;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (timeout_hit) begin
                        htrans_q      <= TRANS_IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_RESP;
                    end else if (HREADY) begin
                        htrans_q <= TRANS_IDLE;
                        state_q  <= ST_DATA;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                ST_DATA: begin
                    // HRESP is only meaningful on the edge that also has HREADY high.
                    if (timeout_hit) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_RESP;
                    end else if (HREADY) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= (!hwrite_q && !HRESP) ? HRDATA : 32'h0;
                        rsp_err_q     <= HRESP;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    htrans_q    <= TRANS_IDLE;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign HADDR       = haddr_q;
    assign HTRANS      = htrans_q;
    assign HWRITE      = hwrite_q;
    assign HSIZE       = 3'b010;
    assign HWDATA      = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomised bench for ahb_lite_master: a planned-stall AHB slave, a word-memory
// reference model and a scoreboard checked by an independent response monitor.
module tb_ahb_lite_master;
    localparam int TO    = 6;
    localparam int STUCK = 99;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE;

    ahb_lite_master #(.TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          a;     // HREADY-low cycles in the address phase
        int          d;     // HREADY-low cycles in the data phase
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          lat;   // command-to-response latency in cycles
        int          nseq;  // NONSEQ bus cycles for this transfer
        int          acc;
    } exp_t;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [31:0] model_mem [256];
    logic [31:0] slave_mem [256];
    int          tests   = 0;
    int          fails   = 0;
    int          last_hs = -100;
    int          bp_hold = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: out-of-range (>= 1 KiB) is an error, a total stall of TO or more
    // cycles is a timeout, otherwise a plain word memory.
    function automatic exp_t predict(input plan_t p, input int acc);
        exp_t e;
        logic to;
        to      = (p.a + p.d) >= TO;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.to    = 1'b0;
        e.acc   = acc;
        if (to) begin
            e.err = 1'b1;
            e.to  = 1'b1;
        end else if (p.addr >= 32'h400) begin
            e.err = 1'b1;
        end else if (p.wr) begin
            model_mem[p.addr[9:2]] = p.wdata;
        end else begin
            e.rdata = model_mem[p.addr[9:2]];
        end
        if (!to)          e.lat = 3 + p.a + p.d;
        else if (p.a >= TO) e.lat = TO + 2;
        else              e.lat = TO + 3;
        e.nseq = (p.a >= TO) ? TO + 1 : p.a + 1;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input plan_t p);
        int   budget;
        logic waited;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = p.wr;
        cmd_addr  = p.addr;
        cmd_wdata = p.wdata;
        budget    = 0;
        waited    = 1'b0;
        while (!cmd_ready) begin
            waited = 1'b1;
            @(negedge HCLK);
            budget++;
            if (budget > 300) begin
                check("cmd_accept_bound", 32'd0, 32'd1);
                cmd_valid = 1'b0;
                return;
            end
        end
        e = predict(p, cyc + 1);
        exp_q.push_back(e);
        plan_q.push_back(p);
        if (waited) check("accept_after_handshake", cyc + 1, last_hs + 1);
        $display("[TB] cmd %s addr=0x%08h wdata=0x%08h stall=%0d/%0d", p.wr ? "WR" : "RD",
                 p.addr, p.wdata, p.a, p.d);
        @(negedge HCLK);
        cmd_valid = 1'b0;
        cmd_write = $urandom_range(0, 1);
        cmd_addr  = $urandom();
        cmd_wdata = $urandom();
    endtask

    function automatic plan_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                 input int a, input int d);
        plan_t p;
        p.wr = wr; p.addr = addr; p.wdata = wd; p.a = a; p.d = d;
        return p;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_haddr"}, HADDR, 0);
        check({tag, "_htrans"}, HTRANS, 0);
        check({tag, "_hwrite"}, HWRITE, 0);
        check({tag, "_hwdata"}, HWDATA, 0);
        check({tag, "_hsize"}, HSIZE, 3'b010);
    endtask

    // AHB slave: follows the stall plan of each transfer, memory of 256 words.
    initial begin : slave
        int          ph;
        int          a_rem;
        int          d_rem;
        plan_t       cur;
        logic [31:0] sa;
        logic        sw;
        ph = 0; a_rem = 0; d_rem = 0; sa = '0; sw = 1'b0;
        cur = mk(1'b0, 32'h0, 32'h0, 0, 0);
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        forever begin
            @(negedge HCLK);
            HREADY = 1'b1;
            HRESP  = 1'b0;
            HRDATA = $urandom();
            if (!HRESETn || rsp_valid) begin
                ph = 0;
            end else begin
                if (ph == 0 && HTRANS == 2'b10) begin
                    if (plan_q.size() == 0) begin
                        check("nonseq_without_command", 32'd1, 32'd0);
                    end else begin
                        cur   = plan_q.pop_front();
                        a_rem = cur.a;
                        ph    = 1;
                        check("haddr", HADDR, {cur.addr[31:2], 2'b00});
                        check("hwrite", HWRITE, cur.wr);
                        check("hsize", HSIZE, 3'b010);
                    end
                end
                if (ph == 1) begin
                    if (a_rem > 0) begin
                        check("addr_stall_htrans", HTRANS, 2'b10);
                        check("addr_stall_haddr", HADDR, {cur.addr[31:2], 2'b00});
                        HREADY = 1'b0;
                        a_rem--;
                    end else begin
                        sa = HADDR; sw = HWRITE; d_rem = cur.d; ph = 2;
                    end
                end else if (ph == 2) begin
                    check("data_phase_htrans", HTRANS, 2'b00);
                    if (d_rem > 0) begin
                        HREADY = 1'b0;
                        HRESP  = (sa >= 32'h400) && (d_rem == 1);
                        d_rem--;
                    end else begin
                        if (sa >= 32'h400) HRESP = 1'b1;
                        else if (sw)       slave_mem[sa[9:2]] = HWDATA;
                        else               HRDATA = slave_mem[sa[9:2]];
                        ph = 3;
                    end
                end
            end
        end
    end

    // Response monitor: latency, stability while stalled, and scoreboard compare.
    initial begin : monitor
        logic        prev_v;
        int          nseq;
        exp_t        e;
        logic [31:0] f_rdata;
        logic        f_err, f_to;
        prev_v = 1'b0; nseq = 0; f_rdata = '0; f_err = 1'b0; f_to = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                prev_v = 1'b0; nseq = 0; rsp_ready = 1'b0;
                continue;
            end
            if (HTRANS == 2'b10) nseq++;
            if (rsp_valid) begin
                check("cmd_ready_in_resp", cmd_ready, 0);
                if (!prev_v) begin
                    f_rdata = rsp_rdata; f_err = rsp_err; f_to = rsp_timeout;
                    if (exp_q.size() == 0) check("unexpected_response", 32'd1, 32'd0);
                    else check("latency", cyc - exp_q[0].acc + 1, exp_q[0].lat);
                end else begin
                    check("stable_rdata", rsp_rdata, f_rdata);
                    check("stable_err", rsp_err, f_err);
                    check("stable_timeout", rsp_timeout, f_to);
                end
            end
            prev_v = rsp_valid;
            if (bp_hold > 0 && rsp_valid) begin
                rsp_ready = 1'b0;
                bp_hold--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("[TB] rsp rdata=0x%08h err=%0d timeout=%0d (want 0x%08h %0d %0d)",
                         rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
                check("rsp_timeout", rsp_timeout, e.to);
                check("nonseq_cycles", nseq, e.nseq);
                nseq    = 0;
                prev_v  = 1'b0;
                last_hs = cyc + 1;
            end
        end
    end

    initial begin : driver
        plan_t p;
        int    a;
        int    k;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 32'h0;
            slave_mem[i] = 32'h0;
        end
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        HRESETn = 1'b1;
        #1 HRESETn = 1'b0;
        #2 check_reset_state("reset");
        repeat (3) @(negedge HCLK);
        #2 HRESETn = 1'b1;
        @(negedge HCLK);

        send(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0));
        send(mk(1'b0, 32'h0000_0010, 32'h0, 0, 0));
        send(mk(1'b0, 32'h0000_0400, 32'h0, 0, 0));
        send(mk(1'b1, 32'h0000_0008, 32'h1234_5678, 0, 0));
        send(mk(1'b0, 32'h0000_0008, 32'h0, 2, 3));
        bp_hold = 5;
        send(mk(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 0, 1));
        send(mk(1'b0, 32'h0000_0022, 32'h0, 1, 0));
        send(mk(1'b0, 32'h0000_0010, 32'h0, 1, STUCK));
        send(mk(1'b1, 32'h0000_0014, 32'h5555_AAAA, STUCK, 0));
        send(mk(1'b0, 32'h0000_0014, 32'h0, 0, 0));

        // Reset while the data phase of a stuck read is in progress.
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge HCLK);
        send(mk(1'b0, 32'h0000_0020, 32'h0, 0, STUCK));
        @(negedge HCLK);
        #2 HRESETn = 1'b0;
        exp_q.delete();
        plan_q.delete();
        #1 check_reset_state("mid_reset");
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
        @(negedge HCLK);
        check("post_reset_cmd_ready", cmd_ready, 1);
        send(mk(1'b1, 32'h0000_0024, 32'h0BAD_C0DE, 0, 0));
        send(mk(1'b0, 32'h0000_0024, 32'h0, 0, 0));

        for (int n = 0; n < 60; n++) begin
            p.wr    = $urandom_range(0, 1);
            p.addr  = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) p.addr = p.addr + 32'h400;
            p.wdata = $urandom();
            a       = $urandom_range(0, 2);
            p.a     = a;
            p.d     = $urandom_range(0, TO - 1 - a);
            k       = $urandom_range(0, 19);
            if (k == 0) p.a = STUCK;
            if (k == 1) p.d = STUCK;
            if ($urandom_range(0, 9) == 0) bp_hold = $urandom_range(1, 4);
            send(p);
            repeat ($urandom_range(0, 2)) @(negedge HCLK);
        end

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge HCLK);
        check("drain_responses", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

Single-outstanding AHB-Lite master that turns a simple valid/ready command interface into NONSEQ single-word transfers, and returns read data and error status on a valid/ready response interface. It sits directly upstream of the AHB slaves in the simulation subsystem, such as `ahb_memory`, and drives their address/control and write-data buses. Transfers are never pipelined. Every NONSEQ is followed by IDLE cycles. A slave that only registers a new transfer after an IDLE cycle is therefore always served correctly.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of HREADY-low cycles tolerated per transfer before abort; 0 disables the timeout.
- `HCLK` in 1: system clock; all state updates on the rising edge.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: byte address.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed on an edge where `rsp_valid && rsp_ready`.
- `rsp_rdata` out 32: read data; 0 for writes, errors and timeouts.
- `rsp_err` out 1: slave returned HRESP=1, or timeout.
- `rsp_timeout` out 1: transfer aborted by timeout.
- `HADDR` out 32: AHB address.
- `HTRANS` out 2: AHB transfer type; only IDLE (00) and NONSEQ (10) are used.
- `HWRITE` out 1: AHB write.
- `HSIZE` out 3: constant 3'b010 (word).
- `HWDATA` out 32: AHB write data.
- `HRDATA` in 32: AHB read data.
- `HREADY` in 1: transfer ready from the slave or interconnect.
- `HRESP` in 1: 0 = OKAY, 1 = ERROR.

## Operation
- FSM states are IDLE, ADDR, DATA and RESP. All outputs are registered or decoded from state and registers only; there are no combinational input-to-output paths.
- **IDLE**
  - `cmd_ready`=1 and `HTRANS`=IDLE.
  - On command acceptance, latch write, address and wdata, clear the wait counter, and go to ADDR.
- **ADDR**
  - Drive `HTRANS`=NONSEQ, `HADDR`={addr[31:2],2'b00} and `HWRITE`=latched write.
  - On an edge with `HREADY`=1, go to DATA.
  - Otherwise hold all values and increment the wait counter.
- **DATA**
  - Drive `HTRANS`=IDLE and `HWDATA`=latched wdata. `HADDR` and `HWRITE` hold their values.
  - On an edge with `HREADY`=1, capture `rsp_rdata`=HRDATA for a read or 0 for a write, capture `rsp_err`=HRESP, set `rsp_timeout`=0, and go to RESP. If HRESP=1, `rsp_rdata`=0.
  - `HRESP`=1 while `HREADY`=0 (first cycle of a two-cycle error) is ignored; the master keeps waiting.
- **Timeout**
  - The wait counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates.
  - When it reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0) in ADDR or DATA, go to RESP with `rsp_err`=1, `rsp_timeout`=1 and `rsp_rdata`=0.
  - `HTRANS` is IDLE from the next cycle.
- **RESP**
  - `rsp_valid`=1, with `rsp_*` stable until the handshake; then go to IDLE.
  - `cmd_ready`=0 in every state except IDLE.
- `HWDATA` holds its last value outside DATA; it changes only when a new command is latched.
- **Reset**, asserted at any time:
  - The FSM goes to IDLE immediately; any in-flight transfer and undelivered response are dropped.
  - Outputs reset to: `cmd_ready`=1, `rsp_valid`=0, `rsp_*`=0, `HADDR`=0, `HTRANS`=IDLE, `HWRITE`=0, `HWDATA`=0, `HSIZE`=3'b010.

## Timing
- Command accepted at edge E0:
  - NONSEQ is on the bus in cycle E0→E1.
  - With zero wait states, the data phase is E1→E2 and the slave is sampled at E2.
  - `rsp_valid` rises after E2.
  - Command-to-response latency is 3 cycles plus the number of HREADY-low cycles.
- Minimum spacing is 4 cycles per transfer with `rsp_ready` tied high, because RESP→IDLE→ADDR always inserts at least 2 IDLE bus cycles.
- `cmd_valid` held high while in RESP is not accepted until the FSM is back in IDLE.
- The address phase and data phase each stall independently on HREADY.

## Test plan
- **Write then read, zero wait states** (`ahb_memory`, MEM_DEPTH=256): write 0x0000_0010 ← 0xDEADBEEF, then read 0x0000_0010.
  - Both responses have `rsp_err`=0; the read returns `rsp_rdata`=0xDEADBEEF.
  - NONSEQ is high exactly 1 cycle per transfer, with latency 3 cycles.
- **Out-of-range read**: read 0x0000_0400 → `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- **Wait states**: `HREADY` low for 2 cycles in ADDR and 3 in DATA on a read of 0x8 preloaded with 0x1234_5678.
  - `HADDR`/`HTRANS` are held throughout; the response arrives after 3+5=8 cycles with data 0x1234_5678.
- **Response backpressure**: `rsp_ready`=0 for 5 cycles with `cmd_valid` held high.
  - `rsp_valid` and data stay stable, `cmd_ready`=0, and no second NONSEQ is issued; the next command is accepted 1 cycle after the handshake.
- **Timeout**: with TIMEOUT_CYCLES=4 and `HREADY` stuck at 0 in DATA, the response carries `rsp_err`=1 and `rsp_timeout`=1 after 4 stalled cycles.
- **Reset mid-transfer**: `HRESETn` dropped in DATA.
  - `HTRANS`=IDLE and `rsp_valid`=0 asynchronously.
  - After release, `cmd_ready`=1 and a new write completes normally.
